// File: rtl/train_route_sequencer.sv
// Train route sequencer: walks a route step by step, gating the motor on a debounced
// per-step sensor condition with a per-step timeout. Optional feature macro: ROUTE_LOOP_EN.
module train_route_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned DEBOUNCE       = 4
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       Start,
  input  logic       Abort,
  input  logic [3:0] RouteLen,
  input  logic       SyncIn,
  output logic [4:0] Selector,
  output logic       SyncEnable,
  output logic       Motor,
  output logic       Busy,
  output logic       Done,
  output logic       Fault
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARM     = 3'd1,
    WAIT    = 3'd2,
    ADVANCE = 3'd3,
    DONE    = 3'd4,
    FAULT   = 3'd5
  } state_t;

  localparam logic [4:0]  DEB_L = 5'(DEBOUNCE);
  localparam logic [16:0] TMO_L = 17'(TIMEOUT_CYCLES);

  state_t      state_r;
  state_t      nextState_s;
  logic [3:0]  sel_r;
  logic [3:0]  selNext_s;
  logic [3:0]  routeLen_r;
  logic [3:0]  lenNext_s;
  logic [3:0]  debCnt_r;
  logic [3:0]  debNext_s;
  logic [15:0] timer_r;
  logic [15:0] timerNext_s;
  logic [4:0]  debInc_s;
  logic [16:0] timInc_s;
  logic        debHit_s;
  logic        tmoHit_s;
  logic        wrapDone_s;
  logic        syncEn_r;
  logic        syncEnNext_s;
  logic        motor_r;
  logic        motorNext_s;
  logic        busy_r;
  logic        busyNext_s;
  logic        done_r;
  logic        doneNext_s;
  logic        fault_r;
  logic        faultNext_s;

  // Next-state and step bookkeeping; Abort overrides every state.
  always_comb begin
    nextState_s = state_r;
    selNext_s   = sel_r;
    lenNext_s   = routeLen_r;
    wrapDone_s  = 1'b0;
    debInc_s    = {1'b0, debCnt_r} + 5'd1;
    timInc_s    = {1'b0, timer_r} + 17'd1;
    debHit_s    = SyncIn && (debInc_s == DEB_L);
    tmoHit_s    = (timInc_s == TMO_L);
    if (Abort) begin
      nextState_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (Start) begin
            nextState_s = ARM;
            selNext_s   = 4'd0;
            lenNext_s   = RouteLen;
          end else begin
            nextState_s = IDLE;
          end
        end
        ARM: begin
          nextState_s = WAIT;
        end
        WAIT: begin
          // a debounce completing on the expiry cycle still advances
          if (debHit_s) begin
            nextState_s = ADVANCE;
          end else if (tmoHit_s) begin
            nextState_s = FAULT;
          end else begin
            nextState_s = WAIT;
          end
        end
        ADVANCE: begin
          if (sel_r == routeLen_r) begin
`ifdef ROUTE_LOOP_EN
            nextState_s = ARM;
            selNext_s   = 4'd0;
            wrapDone_s  = 1'b1;
`else
            nextState_s = DONE;
`endif
          end else begin
            nextState_s = ARM;
            selNext_s   = sel_r + 4'd1;
          end
        end
        DONE: begin
          nextState_s = IDLE;
        end
        FAULT: begin
          if (Start) begin
            nextState_s = ARM;
            selNext_s   = 4'd0;
            lenNext_s   = RouteLen;
          end else begin
            nextState_s = FAULT;
          end
        end
        default: begin
          nextState_s = IDLE;
        end
      endcase
    end
  end

  // Output and counter values for the cycle following the coming edge.
  always_comb begin
    debNext_s    = 4'd0;
    timerNext_s  = 16'd0;
    syncEnNext_s = 1'b0;
    if ((state_r == WAIT) && (nextState_s == WAIT)) begin
      debNext_s   = SyncIn ? debInc_s[3:0] : 4'd0;
      timerNext_s = timInc_s[15:0];
    end else begin
      debNext_s   = 4'd0;
      timerNext_s = 16'd0;
    end
    case (nextState_s)
      ARM:     syncEnNext_s = 1'b1;
      WAIT:    syncEnNext_s = ~syncEn_r;
      default: syncEnNext_s = 1'b0;
    endcase
    motorNext_s = (nextState_s == ARM) || (nextState_s == WAIT) || (nextState_s == ADVANCE);
    busyNext_s  = motorNext_s || (nextState_s == DONE);
    doneNext_s  = (nextState_s == DONE) || wrapDone_s;
    faultNext_s = (nextState_s == FAULT);
  end

  // State, step index and latched route length.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_r    <= IDLE;
      sel_r      <= 4'd0;
      routeLen_r <= 4'd0;
      debCnt_r   <= 4'd0;
      timer_r    <= 16'd0;
    end else begin
      state_r    <= nextState_s;
      sel_r      <= selNext_s;
      routeLen_r <= lenNext_s;
      debCnt_r   <= debNext_s;
      timer_r    <= timerNext_s;
    end
  end

  // Registered outputs.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      syncEn_r <= 1'b0;
      motor_r  <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      fault_r  <= 1'b0;
    end else begin
      syncEn_r <= syncEnNext_s;
      motor_r  <= motorNext_s;
      busy_r   <= busyNext_s;
      done_r   <= doneNext_s;
      fault_r  <= faultNext_s;
    end
  end

  assign Selector   = {1'b0, sel_r};
  assign SyncEnable = syncEn_r;
  assign Motor      = motor_r;
  assign Busy       = busy_r;
  assign Done       = done_r;
  assign Fault      = fault_r;

endmodule

// File: tb/tb_train_route_sequencer.sv
// Scoreboard bench for train_route_sequencer: routes are planned at step level into
// per-cycle input/expected frames, a driver plays them and a monitor compares.
module tb_train_route_sequencer;

  localparam int TMO = 10;
  localparam int DEB = 4;

  logic       Clk = 1'b0;
  logic       Rst_n;
  logic       Start;
  logic       Abort;
  logic [3:0] RouteLen;
  logic       SyncIn;
  logic [4:0] Selector;
  logic       SyncEnable;
  logic       Motor;
  logic       Busy;
  logic       Done;
  logic       Fault;

  always #5 Clk = ~Clk;

  train_route_sequencer #(.TIMEOUT_CYCLES(TMO), .DEBOUNCE(DEB)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Abort(Abort), .RouteLen(RouteLen),
    .SyncIn(SyncIn), .Selector(Selector), .SyncEnable(SyncEnable), .Motor(Motor),
    .Busy(Busy), .Done(Done), .Fault(Fault)
  );

  typedef struct packed { logic st; logic ab; logic sy; logic [3:0] len; } inFrame_t;
  typedef struct packed { logic [4:0] sel; logic en; logic mo; logic bu; logic dn; logic fl; } outFrame_t;

  inFrame_t  inQ[$];
  outFrame_t planQ[$];
  outFrame_t expQ[$];
  int        forcedSync[$];
  int        heldSel = 0;
  int        inFault = 0;
  int        pOne = 8;
  int        compared = 0;
  int        mismatched = 0;

  function automatic outFrame_t mk(int sel, int en, int mo, int bu, int dn, int fl);
    outFrame_t o;
    o.sel = 5'(sel); o.en = 1'(en); o.mo = 1'(mo); o.bu = 1'(bu); o.dn = 1'(dn); o.fl = 1'(fl);
    return o;
  endfunction

  function automatic int rb();
    return int'($urandom_range(0, 1));
  endfunction

  function automatic int noise();
    return ($urandom_range(0, 3) == 0) ? 1 : 0;
  endfunction

  function automatic int rlen();
    return int'($urandom_range(0, 15));
  endfunction

  function automatic int drawSync();
    if (forcedSync.size() > 0) return forcedSync.pop_front();
    return (int'($urandom_range(0, 9)) < pOne) ? 1 : 0;
  endfunction

  task automatic check(string name, outFrame_t e);
    outFrame_t a;
    a = {Selector, SyncEnable, Motor, Busy, Done, Fault};
    compared++;
    if (a !== e) begin
      mismatched++;
      $display("FAIL %s @%0t: got sel=%0d en=%0b mo=%0b bu=%0b dn=%0b fl=%0b, expected sel=%0d en=%0b mo=%0b bu=%0b dn=%0b fl=%0b",
               name, $time, a.sel, a.en, a.mo, a.bu, a.dn, a.fl, e.sel, e.en, e.mo, e.bu, e.dn, e.fl);
    end
  endtask

  task automatic put(int st, int ab, int sy, int len, outFrame_t o);
    inFrame_t f;
    f.st = 1'(st); f.ab = 1'(ab); f.sy = 1'(sy); f.len = 4'(len);
    inQ.push_back(f);
    planQ.push_back(o);
  endtask

  task automatic putAbort(int sel);
    put(rb(), 1, rb(), rlen(), mk(sel, 0, 0, 0, 0, 0));
    heldSel = sel;
    inFault = 0;
  endtask

  // One route from a Start in IDLE/FAULT; abortAt counts cycles after the Start cycle.
  task automatic planRoute(int len, int abortAt);
    int sel; int c; int run; int t; int en; int s; int fin;
    sel = 0; c = 0;
`ifdef ROUTE_LOOP_EN
    if (abortAt < 0) abortAt = 40;
`endif
    put(1, 0, rb(), len, mk(0, 1, 1, 1, 0, 0));
    inFault = 0;
    forever begin
      if (c == abortAt) begin putAbort(sel); return; end
      c++;
      put(noise(), 0, rb(), rlen(), mk(sel, 0, 1, 1, 0, 0));
      en = 0; run = 0; t = 0; fin = 0;
      while (fin == 0) begin
        if (c == abortAt) begin putAbort(sel); return; end
        c++;
        s = drawSync();
        run = (s != 0) ? run + 1 : 0;
        t++;
        if (run == DEB) begin
          put(noise(), 0, s, rlen(), mk(sel, 0, 1, 1, 0, 0));
          fin = 1;
        end else if (t == TMO) begin
          put(noise(), 0, s, rlen(), mk(sel, 0, 0, 0, 0, 1));
          inFault = 1;
          heldSel = sel;
          return;
        end else begin
          en = 1 - en;
          put(noise(), 0, s, rlen(), mk(sel, en, 1, 1, 0, 0));
        end
      end
      if (c == abortAt) begin putAbort(sel); return; end
      c++;
      if (sel == len) begin
`ifdef ROUTE_LOOP_EN
        sel = 0;
        put(noise(), 0, rb(), rlen(), mk(0, 1, 1, 1, 1, 0));
`else
        put(noise(), 0, rb(), rlen(), mk(sel, 0, 0, 1, 1, 0));
        if (c == abortAt) begin putAbort(sel); return; end
        put(noise(), 0, rb(), rlen(), mk(sel, 0, 0, 0, 0, 0));
        heldSel = sel;
        return;
`endif
      end else begin
        sel++;
        put(noise(), 0, rb(), rlen(), mk(sel, 1, 1, 1, 0, 0));
      end
    end
  endtask

  task automatic play();
    inFrame_t f;
    outFrame_t o;
    while (inQ.size() > 0) begin
      @(negedge Clk);
      f = inQ.pop_front();
      o = planQ.pop_front();
      Start = f.st; Abort = f.ab; SyncIn = f.sy; RouteLen = f.len;
      expQ.push_back(o);
    end
    @(negedge Clk);
    Start = 1'b0; Abort = 1'b0;
  endtask

  task automatic route(int len, int abortAt);
    planRoute(len, abortAt);
    forcedSync.delete();
    play();
  endtask

  task automatic idle(int n);
    int st; int ab;
    for (int k = 0; k < n; k++) begin
      ab = noise();
      st = (ab != 0) ? rb() : 0;
      if (ab != 0) inFault = 0;
      put(st, ab, rb(), rlen(), mk(heldSel, 0, 0, 0, 0, inFault));
    end
    play();
  endtask

  // Monitor: one expected frame per clock once the driver has issued one.
  initial begin
    outFrame_t e;
    forever begin
      @(posedge Clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        check("frame", e);
      end
    end
  end

  initial begin
    Rst_n = 1'b0; Start = 1'b0; Abort = 1'b0; RouteLen = 4'd0; SyncIn = 1'b0;
    repeat (3) @(posedge Clk);
    #1 check("reset_state", mk(0, 0, 0, 0, 0, 0));
    @(negedge Clk);
    Rst_n = 1'b1;

    forcedSync = '{1, 1, 1, 0, 1, 1, 1, 1};
    route(0, -1);
    forcedSync = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
    route(2, -1);
    forcedSync = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    route(1, -1);
    idle(3);
    forcedSync = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1};
    route(0, -1);
    forcedSync = '{1, 1, 1, 1, 1, 1};
    route(2, 8);
    put(1, 1, 0, 5, mk(heldSel, 0, 0, 0, 0, 0));
    play();

    for (int i = 0; i < 40; i++) begin
      pOne = int'($urandom_range(3, 9));
      case ($urandom_range(0, 3))
        0:       idle(int'($urandom_range(1, 4)));
        default: route(int'($urandom_range(0, 3)),
                       ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 25)) : -1);
      endcase
    end

    // asynchronous reset between edges while a step is waiting
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Start = 1'b1; RouteLen = 4'd2;
    @(negedge Clk);
    Start = 1'b0; SyncIn = 1'b0;
    repeat (3) @(negedge Clk);
    #1 check("mid_wait", mk(0, 0, 1, 1, 0, 0));
    #2 Rst_n = 1'b0;
    #1 check("async_reset", mk(0, 0, 0, 0, 0, 0));
    @(negedge Clk);
    Rst_n = 1'b1;
    @(posedge Clk);
    #1 check("after_reset", mk(0, 0, 0, 0, 0, 0));
    heldSel = 0; inFault = 0;
    forcedSync = '{1, 1, 1, 1};
    route(0, -1);

    repeat (3) @(posedge Clk);
    #2;
    compared++;
    if (expQ.size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d pending frames, expected 0", expQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/train_route_sequencer.md
TRAIN_ROUTE_SEQUENCER -- requirements
Module: train_route_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1000, max cycles allowed in WAIT per step before fault; SHALL be 2..65535.
REQ-002 Parameter DEBOUNCE, default 4, consecutive SyncIn=1 samples needed to accept a step; SHALL be 1..15.
REQ-003 Clk  input  1  sole clock, rising edge.
REQ-004 Rst_n  input  1  asynchronous active-low reset.
REQ-005 Start  input  1  one-cycle request to run a route from step 0.
REQ-006 Abort  input  1  stop the route immediately.
REQ-007 RouteLen  input  4  index of the last step; latched at accepted Start.
REQ-008 SyncIn  input  1  sensor condition for the current step, from the synchronizer Y output.
REQ-009 Selector  output  5  current step index to the synchronizer; bit 4 always 0.
REQ-010 SyncEnable  output  1  evaluation strobe to the synchronizer Enable input.
REQ-011 Motor  output  1  train motor run command.
REQ-012 Busy  output  1  route in progress.
REQ-013 Done  output  1  one-cycle route-complete pulse.
REQ-014 Fault  output  1  sticky step-timeout flag.

Function
REQ-015 FSM states SHALL be IDLE, ARM, WAIT, ADVANCE, DONE and FAULT; all outputs SHALL be registered.
REQ-016 IDLE: Start=1 and Abort=0 -> ARM; Selector<=0; RouteLen latched.
REQ-017 ARM: exactly one cycle; SyncEnable=1, Motor=1, Busy=1; step timer and debounce counter cleared; -> WAIT.
REQ-018 WAIT: Motor=1, Busy=1; SyncEnable SHALL toggle every cycle so that the synchronizer re-evaluates; SyncIn SHALL be sampled every WAIT cycle.
REQ-019 Debounce counter SHALL increment on SyncIn=1, clear on SyncIn=0; on reaching DEBOUNCE -> ADVANCE next cycle.
REQ-020 Step timer SHALL count WAIT cycles; on reaching TIMEOUT_CYCLES with debounce incomplete -> FAULT; when debounce completes on the same cycle the timer expires, debounce SHALL win.
REQ-021 ADVANCE: one cycle, Motor=1; Selector==latched RouteLen -> DONE, otherwise Selector<=Selector+1 and -> ARM.
REQ-022 DONE: one cycle; Done=1, Motor=0, Busy=1; -> IDLE; Selector SHALL hold its last value in IDLE.
REQ-023 FAULT: Motor=0, Busy=0, Fault=1; Selector holds; Start -> clear Fault, Selector<=0, ARM; Abort -> clear Fault, IDLE.
REQ-024 Abort SHALL have priority over every other event in every state: next state IDLE, Motor=0, Busy=0, no Done, no Fault set.
REQ-025 Start SHALL be ignored while Busy=1; Start and Abort together in IDLE -> stay IDLE.
REQ-026 Latency: Start at cycle n -> Busy=1, Motor=1, Selector=0 at n+1.
REQ-027 RouteLen=0 SHALL give a single-step route.

Reset
REQ-028 Rst_n=0 SHALL asynchronously force IDLE, Selector=0, SyncEnable=0, Motor=0, Busy=0, Done=0, Fault=0, and clear all counters; deassertion SHALL be synchronous to Clk.
REQ-029 Reset mid-route SHALL drop Motor within the reset assertion, with no Done pulse.

Configuration
REQ-030 Macro ROUTE_LOOP_EN defined: ADVANCE at the last step SHALL pulse Done for one cycle, set Selector<=0 and go to ARM (continuous loop until Abort or fault); Motor stays 1.
REQ-031 ROUTE_LOOP_EN undefined: behaviour per REQ-021/REQ-022; the route runs once.

Verification
REQ-032 RouteLen=2, DEBOUNCE=4, SyncIn held 1 after each ARM -> Selector 0,1,2 in turn, each step 1+4+1 cycles, Done pulse once, then Motor=0, Busy=0.
REQ-033 DEBOUNCE=4, SyncIn pattern 1,1,1,0,1,1,1,1 in WAIT -> ADVANCE only after the 8th sample.
REQ-034 TIMEOUT_CYCLES=10, SyncIn=0 -> Fault=1 and Motor=0 after 10 WAIT cycles; Start then clears Fault with Selector=0.
REQ-035 Abort at step 1 during WAIT -> IDLE next cycle, Motor=0, Done never pulses, Selector holds 1.
REQ-036 Rst_n pulled low mid-WAIT between clock edges -> all outputs 0 immediately.
REQ-037 ROUTE_LOOP_EN, RouteLen=1 -> Selector sequence 0,1,0,1..., Done pulses at each wrap, Busy stays 1.
